// File: rtl/arc4_ctrl.sv
// arc4_ctrl: top-level ARC4 sequencer. Runs init, ksa and prga in order through
// their en/rdy handshakes, routes the active block onto the single S-memory
// write port, and flags any phase whose block never returns rdy.
module arc4_ctrl #(
    parameter int unsigned      ADDR_W  = 8,
    parameter int unsigned      DATA_W  = 8,
    parameter int unsigned      TMO_W   = 16,
    parameter logic [TMO_W-1:0] TMO_MAX = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    output logic              done,
    output logic              err,
    output logic [1:0]        phase,
    output logic              init_en,
    input  logic              init_rdy,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_wrdata,
    input  logic              init_wren,
    output logic              ksa_en,
    input  logic              ksa_rdy,
    input  logic [ADDR_W-1:0] ksa_addr,
    input  logic [DATA_W-1:0] ksa_wrdata,
    input  logic              ksa_wren,
    output logic              prga_en,
    input  logic              prga_rdy,
    input  logic [ADDR_W-1:0] prga_addr,
    input  logic [DATA_W-1:0] prga_wrdata,
    input  logic              prga_wren,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wrdata,
    output logic              s_wren
);

    typedef enum logic [2:0] {
        IDLE,
        I_START,
        I_WAIT,
        K_START,
        K_WAIT,
        P_START,
        P_WAIT,
        ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [TMO_W-1:0] wdog_q, wdog_d, wdog_inc;
    logic             err_q, err_d;
    logic [1:0]       ephase_q, ephase_d;
    logic             timeout;

    // Saturating watchdog increment; expiry counts the current wait cycle.
    always_comb begin
        wdog_inc = (wdog_q == '1) ? wdog_q : wdog_q + TMO_W'(1);
        timeout  = (TMO_MAX != '0) && (wdog_inc >= TMO_MAX);
    end

    // State, watchdog, sticky error and failing-phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wdog_q   <= '0;
            err_q    <= 1'b0;
            ephase_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            wdog_q   <= wdog_d;
            err_q    <= err_d;
            ephase_q <= ephase_d;
        end
    end

    // Next-state logic and handshake pulses; a ready block wins over expiry.
    always_comb begin
        state_d  = state_q;
        wdog_d   = wdog_q;
        err_d    = err_q;
        ephase_d = ephase_q;
        init_en  = 1'b0;
        ksa_en   = 1'b0;
        prga_en  = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE, ERROR: begin
                if (en) begin
                    state_d = I_START;
                    err_d   = 1'b0;
                end
            end
            I_START: begin
                wdog_d = '0;
                if (init_rdy) begin
                    init_en = 1'b1;
                    state_d = I_WAIT;
                end
            end
            I_WAIT: begin
                wdog_d = wdog_inc;
                if (init_rdy) begin
                    state_d = K_START;
                end else if (timeout) begin
                    state_d  = ERROR;
                    err_d    = 1'b1;
                    ephase_d = 2'd1;
                end
            end
            K_START: begin
                wdog_d = '0;
                if (ksa_rdy) begin
                    ksa_en  = 1'b1;
                    state_d = K_WAIT;
                end
            end
            K_WAIT: begin
                wdog_d = wdog_inc;
                if (ksa_rdy) begin
                    state_d = P_START;
                end else if (timeout) begin
                    state_d  = ERROR;
                    err_d    = 1'b1;
                    ephase_d = 2'd2;
                end
            end
            P_START: begin
                wdog_d = '0;
                if (prga_rdy) begin
                    prga_en = 1'b1;
                    state_d = P_WAIT;
                end
            end
            P_WAIT: begin
                wdog_d = wdog_inc;
                if (prga_rdy) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (timeout) begin
                    state_d  = ERROR;
                    err_d    = 1'b1;
                    ephase_d = 2'd3;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status decode: ready when idle or errored; ERROR reports the failing phase.
    always_comb begin
        rdy   = 1'b0;
        phase = 2'd0;
        err   = err_q;
        case (state_q)
            IDLE:             rdy = 1'b1;
            I_START, I_WAIT:  phase = 2'd1;
            K_START, K_WAIT:  phase = 2'd2;
            P_START, P_WAIT:  phase = 2'd3;
            ERROR: begin
                rdy   = 1'b1;
                phase = ephase_q;
            end
            default: ;
        endcase
    end

    // S-memory write-port mux; idle and error park the port at zero.
    always_comb begin
        s_addr   = '0;
        s_wrdata = '0;
        s_wren   = 1'b0;
        case (state_q)
            I_START, I_WAIT: begin
                s_addr   = init_addr;
                s_wrdata = init_wrdata;
                s_wren   = init_wren;
            end
            K_START, K_WAIT: begin
                s_addr   = ksa_addr;
                s_wrdata = ksa_wrdata;
                s_wren   = ksa_wren;
            end
            P_START, P_WAIT: begin
                s_addr   = prga_addr;
                s_wrdata = prga_wrdata;
                s_wren   = prga_wren;
            end
            default: ;
        endcase
    end

endmodule
